// File: rtl/ysyx_041461_pipe_ctrl.sv
// Pipeline hazard/stall/flush controller for the 5-stage core.
// Fixed-priority resolution of trap, memory wait, redirect, load-use and fetch wait.
module ysyx_041461_pipe_ctrl #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             EXE_valid,
    input  logic             EXE_is_load,
    input  logic [4:0]       EXE_rd,
    input  logic             EXE_redirect,
    input  logic             IF_ready,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    input  logic             WB_trap,
    output logic             pc_enable,
    output logic [1:0]       pc_sel,
    output logic             IDreg_enable,
    output logic             EXEreg_enable,
    output logic             MEMreg_enable,
    output logic             WBreg_enable,
    output logic             IDreg_flush,
    output logic             EXEreg_flush,
    output logic             MEMreg_flush,
    output logic             WBreg_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StMwait = 2'd1,
        StTrap  = 2'd2
    } state_e;

    localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             trap_pend_q, trap_pend_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [WdW-1:0]   wd_cnt_q, wd_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu;
    logic mstall;
    logic take_trap;

    always_comb begin
        lu = EXE_valid & EXE_is_load & (EXE_rd != 5'd0) &
             ((ID_use_rs1 & (ID_rs1 == EXE_rd)) | (ID_use_rs2 & (ID_rs2 == EXE_rd)));
        mstall    = MEM_req & ~MEM_ready;
        // A pending trap only fires once the FSM has parked in TRAP after the wait ends.
        take_trap = (WB_trap & ~mstall) | ((state_q == StTrap) & trap_pend_q);
    end

    always_comb begin
        pc_enable     = 1'b1;
        pc_sel        = 2'd0;
        IDreg_enable  = 1'b1;
        EXEreg_enable = 1'b1;
        MEMreg_enable = 1'b1;
        WBreg_enable  = 1'b1;
        IDreg_flush   = 1'b0;
        EXEreg_flush  = 1'b0;
        MEMreg_flush  = 1'b0;
        WBreg_flush   = 1'b0;

        if (take_trap) begin
            pc_sel       = 2'd2;
            IDreg_flush  = 1'b1;
            EXEreg_flush = 1'b1;
            MEMreg_flush = 1'b1;
            WBreg_flush  = 1'b1;
        end else if (mstall) begin
            pc_enable     = 1'b0;
            IDreg_enable  = 1'b0;
            EXEreg_enable = 1'b0;
            MEMreg_enable = 1'b0;
            WBreg_flush   = 1'b1;
        end else if (EXE_redirect) begin
            pc_sel       = 2'd1;
            IDreg_flush  = 1'b1;
            EXEreg_flush = 1'b1;
        end else if (lu) begin
            pc_enable    = 1'b0;
            IDreg_enable = 1'b0;
            EXEreg_flush = 1'b1;
        end else if (!IF_ready) begin
            pc_enable   = 1'b0;
            IDreg_flush = 1'b1;
        end

        if (!rst) begin
            pc_enable     = 1'b0;
            pc_sel        = 2'd0;
            IDreg_enable  = 1'b0;
            EXEreg_enable = 1'b0;
            MEMreg_enable = 1'b0;
            WBreg_enable  = 1'b0;
            IDreg_flush   = 1'b0;
            EXEreg_flush  = 1'b0;
            MEMreg_flush  = 1'b0;
            WBreg_flush   = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        trap_pend_d = trap_pend_q;

        unique case (state_q)
            StRun: begin
                if (mstall) begin
                    state_d = StMwait;
                end else if (WB_trap) begin
                    state_d = StTrap;
                end
            end
            StMwait: begin
                if (!mstall) begin
                    state_d = (trap_pend_q | WB_trap) ? StTrap : StRun;
                end
            end
            StTrap: begin
                state_d = mstall ? StMwait : StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (take_trap) begin
            trap_pend_d = 1'b0;
        end else if (mstall & WB_trap) begin
            trap_pend_d = 1'b1;
        end

        // Saturates at the threshold; the flag is sticky so further counting is pointless.
        if ((state_q == StMwait) && (state_d == StMwait)) begin
            wd_cnt_d = (wd_cnt_q == WdMax) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end else begin
            wd_cnt_d = '0;
        end

        mem_timeout_d = mem_timeout_q | ((state_q == StMwait) && (wd_cnt_q == WdMax));
        stall_cnt_d   = stall_cnt_q + {{(CNT_W-1){1'b0}}, ~pc_enable};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StRun;
            trap_pend_q   <= 1'b0;
            mem_timeout_q <= 1'b0;
            wd_cnt_q      <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            trap_pend_q   <= trap_pend_d;
            mem_timeout_q <= mem_timeout_d;
            wd_cnt_q      <= wd_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// Directed bench for ysyx_041461_pipe_ctrl with hand-computed expectations.
module tb_ysyx_041461_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs1, ID_rs2, EXE_rd;
    logic        ID_use_rs1, ID_use_rs2, EXE_valid, EXE_is_load, EXE_redirect;
    logic        IF_ready, MEM_req, MEM_ready, WB_trap;
    logic        pc_enable, IDreg_enable, EXEreg_enable, MEMreg_enable, WBreg_enable;
    logic        IDreg_flush, EXEreg_flush, MEMreg_flush, WBreg_flush, mem_timeout;
    logic [1:0]  pc_sel, state;
    logic [31:0] stall_cnt;
    logic [4:0]  en;
    logic [3:0]  fl;

    int errors = 0;
    int checks = 0;
    int exp_stall = 0;

    assign en = {pc_enable, IDreg_enable, EXEreg_enable, MEMreg_enable, WBreg_enable};
    assign fl = {IDreg_flush, EXEreg_flush, MEMreg_flush, WBreg_flush};

    ysyx_041461_pipe_ctrl #(
        .TIMEOUT(8),
        .CNT_W  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_rs1       (ID_rs1),
        .ID_rs2       (ID_rs2),
        .ID_use_rs1   (ID_use_rs1),
        .ID_use_rs2   (ID_use_rs2),
        .EXE_valid    (EXE_valid),
        .EXE_is_load  (EXE_is_load),
        .EXE_rd       (EXE_rd),
        .EXE_redirect (EXE_redirect),
        .IF_ready     (IF_ready),
        .MEM_req      (MEM_req),
        .MEM_ready    (MEM_ready),
        .WB_trap      (WB_trap),
        .pc_enable    (pc_enable),
        .pc_sel       (pc_sel),
        .IDreg_enable (IDreg_enable),
        .EXEreg_enable(EXEreg_enable),
        .MEMreg_enable(MEMreg_enable),
        .WBreg_enable (WBreg_enable),
        .IDreg_flush  (IDreg_flush),
        .EXEreg_flush (EXEreg_flush),
        .MEMreg_flush (MEMreg_flush),
        .WBreg_flush  (WBreg_flush),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
        EXE_valid = 1'b0; EXE_is_load = 1'b0; EXE_rd = 5'd0; EXE_redirect = 1'b0;
        IF_ready = 1'b1; MEM_req = 1'b0; MEM_ready = 1'b0; WB_trap = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        cyc();
        cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_tmo", 32'(mem_timeout), 32'd0);
        chk("rst_en", 32'(en), 32'h00);
        chk("rst_fl", 32'(fl), 32'h0);
        chk("rst_pcsel", 32'(pc_sel), 32'd0);

        rst = 1'b1;
        #1;
        chk("idle_en", 32'(en), 32'h1f);
        chk("idle_fl", 32'(fl), 32'h0);
        cyc();

        // Load-use on rs1
        EXE_valid = 1'b1; EXE_is_load = 1'b1; EXE_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
        #1;
        chk("lu_en", 32'(en), 32'h07);
        chk("lu_fl", 32'(fl), 32'h4);
        cyc();
        exp_stall = 1;
        chk("lu_stall", stall_cnt, 32'(exp_stall));
        ID_rs1 = 5'd0;
        #1;
        chk("lu_rs0_en", 32'(en), 32'h1f);
        ID_rs1 = 5'd5; EXE_rd = 5'd0;
        #1;
        chk("lu_rd0_en", 32'(en), 32'h1f);
        EXE_rd = 5'd5; ID_use_rs1 = 1'b0; ID_rs2 = 5'd5; ID_use_rs2 = 1'b1;
        #1;
        chk("lu_rs2_en", 32'(en), 32'h07);
        cyc();
        exp_stall = 2;
        EXE_is_load = 1'b0;
        #1;
        chk("noload_en", 32'(en), 32'h1f);

        // Fetch wait
        idle();
        IF_ready = 1'b0;
        #1;
        chk("ifw_en", 32'(en), 32'h0f);
        chk("ifw_fl", 32'(fl), 32'h8);
        cyc();
        exp_stall = 3;
        chk("ifw_stall", stall_cnt, 32'(exp_stall));

        // Redirect together with load-use
        IF_ready = 1'b1;
        EXE_valid = 1'b1; EXE_is_load = 1'b1; EXE_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
        EXE_redirect = 1'b1;
        #1;
        chk("rdlu_pcsel", 32'(pc_sel), 32'd1);
        chk("rdlu_en", 32'(en), 32'h1f);
        chk("rdlu_fl", 32'(fl), 32'hc);
        cyc();
        idle();
        #1;
        chk("rdlu_next_en", 32'(en), 32'h1f);
        chk("rdlu_stall", stall_cnt, 32'(exp_stall));

        // Three-cycle memory wait
        MEM_req = 1'b1; MEM_ready = 1'b0;
        #1;
        chk("mw0_state", 32'(state), 32'd0);
        chk("mw0_en", 32'(en), 32'h01);
        chk("mw0_fl", 32'(fl), 32'h1);
        cyc();
        chk("mw1_state", 32'(state), 32'd1);
        chk("mw1_en", 32'(en), 32'h01);
        cyc();
        chk("mw2_state", 32'(state), 32'd1);
        cyc();
        exp_stall = 6;
        chk("mw_stall", stall_cnt, 32'(exp_stall));
        MEM_ready = 1'b1;
        #1;
        chk("mwr_state", 32'(state), 32'd1);
        chk("mwr_en", 32'(en), 32'h1f);
        chk("mwr_fl", 32'(fl), 32'h0);
        cyc();
        chk("mw_back_run", 32'(state), 32'd0);
        idle();

        // Trap arriving in the second cycle of a four-cycle wait
        MEM_req = 1'b1;
        cyc();
        WB_trap = 1'b1;
        #1;
        chk("tw_defer_fl", 32'(fl), 32'h1);
        chk("tw_defer_pcsel", 32'(pc_sel), 32'd0);
        cyc();
        WB_trap = 1'b0;
        cyc();
        cyc();
        exp_stall = 10;
        MEM_ready = 1'b1;
        #1;
        chk("tw_ready_state", 32'(state), 32'd1);
        chk("tw_ready_fl", 32'(fl), 32'h0);
        cyc();
        idle();
        #1;
        chk("tw_trap_state", 32'(state), 32'd2);
        chk("tw_trap_pcsel", 32'(pc_sel), 32'd2);
        chk("tw_trap_en", 32'(en), 32'h1f);
        chk("tw_trap_fl", 32'(fl), 32'hf);
        cyc();
        chk("tw_after_state", 32'(state), 32'd0);
        chk("tw_after_fl", 32'(fl), 32'h0);
        // A fresh wait must not re-enter TRAP once the pending trap was taken
        MEM_req = 1'b1;
        cyc();
        exp_stall = 11;
        MEM_ready = 1'b1;
        cyc();
        idle();
        #1;
        chk("pend_clear_state", 32'(state), 32'd0);

        // Direct trap from RUN; TRAP without pending trap behaves as RUN
        WB_trap = 1'b1;
        #1;
        chk("dt_pcsel", 32'(pc_sel), 32'd2);
        chk("dt_fl", 32'(fl), 32'hf);
        cyc();
        WB_trap = 1'b0;
        #1;
        chk("dt_state", 32'(state), 32'd2);
        chk("dt_run_pcsel", 32'(pc_sel), 32'd0);
        chk("dt_run_fl", 32'(fl), 32'h0);
        cyc();
        chk("dt_back_run", 32'(state), 32'd0);
        chk("dt_stall", stall_cnt, 32'(exp_stall));

        // Watchdog: flag rises after the eighth MWAIT cycle
        MEM_req = 1'b1; MEM_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("wd_tmo", 32'(mem_timeout), 32'(i >= 9));
            cyc();
        end
        exp_stall = 21;
        chk("wd_still_mwait", 32'(state), 32'd1);
        chk("wd_tmo_set", 32'(mem_timeout), 32'd1);
        MEM_ready = 1'b1;
        cyc();
        idle();
        #1;
        chk("wd_exit_state", 32'(state), 32'd0);
        chk("wd_sticky", 32'(mem_timeout), 32'd1);
        chk("wd_stall", stall_cnt, 32'(exp_stall));

        // Asynchronous reset in the middle of a wait
        MEM_req = 1'b1;
        cyc();
        cyc();
        exp_stall = 23;
        chk("ar_pre_state", 32'(state), 32'd1);
        chk("ar_pre_stall", stall_cnt, 32'(exp_stall));
        #3;
        rst = 1'b0;
        #1;
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_stall", stall_cnt, 32'd0);
        chk("ar_tmo", 32'(mem_timeout), 32'd0);
        chk("ar_en", 32'(en), 32'h00);
        chk("ar_fl", 32'(fl), 32'h0);
        idle();
        cyc();
        rst = 1'b1;
        #1;
        cyc();
        chk("ar_post_state", 32'(state), 32'd0);
        chk("ar_post_tmo", 32'(mem_timeout), 32'd0);
        chk("ar_post_stall", stall_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_041461_pipe_ctrl.md
Name: ysyx_041461_pipe_ctrl

Overview:
Central hazard/stall/flush controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Drives the enable and flush of the PC and of the four stage registers: IDreg (IF→ID), EXEreg (ID→EXE), MEMreg (EXE→MEM), WBreg (MEM→WB).
- Resolves load-use, fetch-wait, data-memory wait, EXE redirect and WB trap by fixed priority.
- Tracks multi-cycle memory waits with an FSM, a watchdog and a stall counter.

Parameters:
- TIMEOUT, 1024: MWAIT cycles before mem_timeout asserts.
- CNT_W, 32: width of stall_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- ID_rs1, ID_rs2  in  5  source regs of the instruction in ID.
- ID_use_rs1, ID_use_rs2  in  1  the source is actually read.
- EXE_valid, EXE_is_load  in  1  EXE holds a valid load.
- EXE_rd  in  5  EXE destination.
- EXE_redirect  in  1  taken branch/jump resolved in EXE.
- IF_ready  in  1  instruction fetch data valid this cycle.
- MEM_req  in  1  MEM stage has an outstanding data access.
- MEM_ready  in  1  data access completes this cycle.
- WB_trap  in  1  valid trapping instruction (ecall/mret/exception) in WB.
- pc_enable  out  1  PC register updates.
- pc_sel  out  2  PC source: 0 = seq, 1 = redirect, 2 = trap.
- IDreg_enable, EXEreg_enable, MEMreg_enable, WBreg_enable  out  1  register loads.
- IDreg_flush, EXEreg_flush, MEMreg_flush, WBreg_flush  out  1  register loads a bubble (valid=0, trap/WB ctrl = NOP).
- mem_timeout  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  cycles with pc_enable=0.
- state  out  2  FSM state, for debug.

Behaviour:
- Any flush=1 forces the matching enable=1.
- Outputs are combinational from inputs and state; counters and flags are registered.
- Reset (rst=0, async):
  - state = RUN; stall_cnt = 0; wd_cnt = 0; mem_timeout = 0; trap_pend = 0.
  - While reset is held, all enables and flushes = 0, pc_enable = 0, pc_sel = 0.
- FSM states: RUN = 0, MWAIT = 1, TRAP = 2.
  - RUN → MWAIT when MEM_req & ~MEM_ready.
  - MWAIT → RUN on MEM_ready, or → TRAP if trap_pend.
  - TRAP → RUN after exactly 1 cycle.
- Hazard detect:
  - lu = EXE_valid & EXE_is_load & EXE_rd≠0 & ((ID_use_rs1 & ID_rs1==EXE_rd) | (ID_use_rs2 & ID_rs2==EXE_rd)).
  - mstall = MEM_req & ~MEM_ready.
- Priority, highest first (default: all enables = 1, flushes = 0, pc_sel = 0):
  1. WB_trap with no mstall, or state TRAP with trap_pend: pc_sel = 2, pc_enable = 1; flush IDreg, EXEreg, MEMreg, WBreg. Clears trap_pend.
  2. mstall (RUN or MWAIT): pc, IDreg, EXEreg, MEMreg hold (enable = 0); WBreg_flush = 1. A WB_trap in this cycle sets trap_pend; the flush is deferred until MEM_ready. The bus access is never abandoned.
  3. EXE_redirect: pc_sel = 1, pc_enable = 1; IDreg_flush = EXEreg_flush = 1; MEMreg, WBreg advance.
  4. lu: pc, IDreg hold; EXEreg_flush = 1; MEMreg, WBreg advance.
  5. ~IF_ready: pc hold; IDreg_flush = 1; the rest advance.
- Simultaneous events: the higher item wins completely; lower-priority events re-evaluate next cycle because their stage registers held. Redirect together with lu: redirect wins and the flushed ID instruction removes the hazard.
- TRAP state with trap_pend = 0 (trap taken directly from RUN): behaves as RUN.
- Watchdog:
  - wd_cnt increments each MWAIT cycle and clears on leaving MWAIT.
  - When wd_cnt reaches TIMEOUT-1, mem_timeout sets and stays set until reset.
  - The FSM stays in MWAIT regardless of the timeout.
- stall_cnt: +1 on every cycle with pc_enable = 0 (reset excluded); wraps modulo 2^CNT_W.
- Reset asserted mid-MWAIT: immediate return to RUN; trap_pend and wd_cnt cleared.

Test Plan:
- Load-use: EXE load, EXE_rd = 5; ID_rs1 = 5, ID_use_rs1 = 1 → pc_enable = 0, IDreg_enable = 0, EXEreg_flush = 1 for 1 cycle; stall_cnt +1. With ID_rs1 = 0 or EXE_rd = 0 → no stall.
- Memory wait: MEM_req = 1, MEM_ready = 0 for 3 cycles → state = 1 for 3 cycles; pc, IDreg, EXEreg, MEMreg held; WBreg_flush = 1; stall_cnt = 3; return to RUN the cycle MEM_ready = 1.
- Trap during wait: WB_trap pulse in cycle 2 of a 4-cycle wait → no flush until MEM_ready; then TRAP state for 1 cycle with pc_sel = 2 and all four flushes = 1; trap_pend clears.
- Redirect + load-use in the same cycle → pc_sel = 1, IDreg_flush = EXEreg_flush = 1, pc_enable = 1; no stall next cycle.
- Watchdog, TIMEOUT = 8: MEM_ready held 0 for 10 cycles → mem_timeout rises after the 8th MWAIT cycle and stays 1 after MEM_ready; cleared only by rst = 0.
- Async reset: assert rst = 0 mid-MWAIT between clock edges → state = 0, stall_cnt = 0, mem_timeout = 0 immediately, without waiting for a clock edge.
